// File: rtl/recon_div_arbiter.sv
// Round-robin front end that shares one pipelined signed divider between N_REQ requesters.
// Each issued operation is tagged with its requester ID, and the result is returned with that ID.
module recon_div_arbiter #(
  parameter int N_REQ       = 2,
  parameter int WIDTH       = 24,
  parameter int DIV_LATENCY = 14,
  parameter int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   flush,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_numer,
  input  logic [N_REQ*WIDTH-1:0] req_denom,
  output logic [WIDTH-1:0]       div_numer,
  output logic [WIDTH-1:0]       div_denom,
  output logic                   div_clken,
  input  logic [WIDTH-1:0]       div_quotient,
  input  logic [WIDTH-1:0]       div_remain,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_quotient,
  output logic [WIDTH-1:0]       rsp_remain,
  output logic                   rsp_div_zero,
  output logic                   busy
);

  typedef struct packed {
    logic            v;
    logic            z;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0]  last_grant_q;
  logic [WIDTH-1:0] div_numer_q, div_denom_q;
  tag_t             iss_tag_q, iss_tag_d;
  tag_t             tag_q [DIV_LATENCY];
  logic             rsp_valid_q, rsp_div_zero_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [WIDTH-1:0] rsp_quotient_q, rsp_remain_q;

  logic             win_found, xfer;
  logic [ID_W-1:0]  win_id, scan_idx;
  logic [WIDTH-1:0] sel_numer, sel_denom;
  logic             busy_c;
  tag_t             last_tag;

  // Scan starts one past the previous winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      scan_idx = ID_W'((32'(last_grant_q) + k) % 32'(N_REQ));
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  assign xfer      = clk_en & ~flush & ~reset & win_found;
  assign req_ready = xfer ? (N_REQ'(1) << win_id) : '0;
  assign sel_numer = req_numer[32'(win_id)*WIDTH +: WIDTH];
  assign sel_denom = req_denom[32'(win_id)*WIDTH +: WIDTH];

  always_comb begin
    iss_tag_d.v  = xfer;
    iss_tag_d.z  = (sel_denom == '0);
    iss_tag_d.id = win_id;
  end

  // The issue-slot tag sits beside div_numer/div_denom. The DIV_LATENCY stages after it
  // track the divider, so the last stage lines up with div_quotient/div_remain.
  assign last_tag = tag_q[DIV_LATENCY-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q   <= ID_W'(N_REQ - 1);
      div_numer_q    <= '0;
      div_denom_q    <= '0;
      iss_tag_q      <= '0;
      for (int unsigned k = 0; k < DIV_LATENCY; k++) tag_q[k] <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_quotient_q <= '0;
      rsp_remain_q   <= '0;
      rsp_div_zero_q <= 1'b0;
    end else if (clk_en) begin
      if (xfer) begin
        div_numer_q  <= sel_numer;
        div_denom_q  <= sel_denom;
        last_grant_q <= win_id;
      end
      iss_tag_q   <= iss_tag_d;
      tag_q[0]    <= iss_tag_q;
      tag_q[0].v  <= iss_tag_q.v & ~flush;
      for (int unsigned k = 1; k < DIV_LATENCY; k++) begin
        tag_q[k]   <= tag_q[k-1];
        tag_q[k].v <= tag_q[k-1].v & ~flush;
      end
      rsp_valid_q <= last_tag.v & ~flush;
      if (last_tag.v && !flush) begin
        rsp_id_q       <= last_tag.id;
        rsp_div_zero_q <= last_tag.z;
        rsp_quotient_q <= last_tag.z ? '0 : div_quotient;
        rsp_remain_q   <= last_tag.z ? '0 : div_remain;
      end
    end
  end

  always_comb begin
    busy_c = rsp_valid_q | iss_tag_q.v;
    for (int unsigned k = 0; k < DIV_LATENCY; k++) busy_c = busy_c | tag_q[k].v;
  end

  assign div_numer    = div_numer_q;
  assign div_denom    = div_denom_q;
  assign div_clken    = clk_en;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_quotient = rsp_quotient_q;
  assign rsp_remain   = rsp_remain_q;
  assign rsp_div_zero = rsp_div_zero_q;
  assign busy         = busy_c;

endmodule

// File: tb/tb_recon_div_arbiter.sv
// Randomized and directed bench for recon_div_arbiter.
// Includes a behavioural divider IP and a scoreboard of expected responses keyed by enabled-edge number.
module tb_recon_div_arbiter;
  localparam int N   = 2;
  localparam int W   = 24;
  localparam int L   = 14;
  localparam int IDW = 1;

  logic           clk = 1'b0;
  logic           reset, clk_en, flush;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_numer, req_denom;
  logic [W-1:0]   div_numer, div_denom, div_quotient, div_remain;
  logic           div_clken, rsp_valid, rsp_div_zero, busy;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_quotient, rsp_remain;

  recon_div_arbiter #(.N_REQ(N), .WIDTH(W), .DIV_LATENCY(L), .ID_W(IDW)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_numer(req_numer), .req_denom(req_denom),
    .div_numer(div_numer), .div_denom(div_denom), .div_clken(div_clken),
    .div_quotient(div_quotient), .div_remain(div_remain),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_quotient(rsp_quotient), .rsp_remain(rsp_remain),
    .rsp_div_zero(rsp_div_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Divider IP: L enabled edges from sampling its inputs to presenting the result.
  logic signed [W-1:0] dpn [L];
  logic signed [W-1:0] dpd [L];
  always @(posedge clk) begin
    if (div_clken) begin
      dpn[0] <= div_numer;
      dpd[0] <= div_denom;
      for (int k = 1; k < L; k++) begin
        dpn[k] <= dpn[k-1];
        dpd[k] <= dpd[k-1];
      end
    end
  end
  always_comb begin
    div_quotient = '0;
    div_remain   = '0;
    if (dpd[L-1] != 0) begin
      div_quotient = dpn[L-1] / dpd[L-1];
      div_remain   = dpn[L-1] % dpd[L-1];
    end
  end

  typedef struct {
    int due;
    int id;
    int q;
    int r;
    bit z;
  } exp_t;

  exp_t   sb[$];
  int     ecount = 0;
  int     ptr    = N - 1;
  logic [N-1:0] pend = '0;
  int     pn [N];
  int     pd [N];
  int     n_vec = 0;
  int     n_err = 0;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic post(input int i, input int n, input int d);
    pend[i] = 1'b1;
    pn[i]   = n;
    pd[i]   = d;
  endtask

  task automatic check_regs();
    while (sb.size() > 0 && sb[0].due < ecount) void'(sb.pop_front());
    chk("busy", busy, sb.size() > 0);
    if (sb.size() > 0 && sb[0].due == ecount) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, sb[0].id);
      chk("rsp_quotient", $signed(rsp_quotient), sb[0].q);
      chk("rsp_remain", $signed(rsp_remain), sb[0].r);
      chk("rsp_div_zero", rsp_div_zero, sb[0].z);
    end else begin
      chk("rsp_valid", rsp_valid, 0);
    end
  endtask

  task automatic cycle(input logic en, input logic fl);
    int   w;
    bit   found;
    logic [N-1:0] exp_rdy;
    exp_t e;
    exp_t keep[$];
    @(negedge clk);
    check_regs();
    clk_en    = en;
    flush     = fl;
    req_valid = pend;
    for (int i = 0; i < N; i++) begin
      req_numer[i*W +: W] = W'(pn[i]);
      req_denom[i*W +: W] = W'(pd[i]);
    end
    #1;
    found = 0;
    w     = 0;
    for (int k = 1; k <= N; k++) begin
      if (!found && pend[(ptr + k) % N]) begin
        found = 1;
        w     = (ptr + k) % N;
      end
    end
    exp_rdy = (en && !fl && !reset && found) ? N'(1) << w : '0;
    chk("req_ready", req_ready, exp_rdy);
    chk("div_clken", div_clken, en);
    @(posedge clk);
    if (en && !reset) begin
      ecount++;
      if (fl) begin
        foreach (sb[j]) if (sb[j].due < ecount) keep.push_back(sb[j]);
        sb = keep;
      end
      if (exp_rdy != 0) begin
        e.due = ecount + L + 1;
        e.id  = w;
        e.z   = (pd[w] == 0);
        e.q   = e.z ? 0 : pn[w] / pd[w];
        e.r   = e.z ? 0 : pn[w] % pd[w];
        sb.push_back(e);
        ptr     = w;
        pend[w] = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() > 0 || pend != 0) && n < 300) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    chk("drain_timeout", n < 300, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_quotient"}, rsp_quotient, 0);
    chk({tag, "_rsp_remain"}, rsp_remain, 0);
    chk({tag, "_rsp_div_zero"}, rsp_div_zero, 0);
    chk({tag, "_div_numer"}, div_numer, 0);
    chk({tag, "_div_denom"}, div_denom, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
  endtask

  int n;

  initial begin
    for (int i = 0; i < N; i++) begin pn[i] = 0; pd[i] = 1; end
    reset = 1'b1; clk_en = 1'b1; flush = 1'b0;
    req_valid = '1; req_numer = '0; req_denom = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    req_valid = '0;
    reset     = 1'b0;

    // Single request: latency counted in enabled edges from the transfer edge.
    post(0, 100, 6);
    cycle(1'b1, 1'b0);
    n = 0;
    while (n < 40) begin
      cycle(1'b1, 1'b0);
      n++;
      #1;
      if (rsp_valid) break;
    end
    chk("latency", n, L + 1);
    drain();
    post(0, -100, 6);
    drain();

    // Contention: both requesters valid for six cycles.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) post(i, 1000 * (c + 1) + i, 7 + i);
      cycle(1'b1, 1'b0);
    end
    pend = '0;
    drain();

    // Stall: two disabled cycles in flight delay the response by exactly two cycles.
    post(0, 100, 6);
    cycle(1'b1, 1'b0);
    n = 0;
    for (int c = 0; c < 3; c++) begin cycle(1'b1, 1'b0); n++; end
    post(1, 7, 2);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    n += 2;
    pend = '0;
    while (n < 60) begin
      cycle(1'b1, 1'b0);
      n++;
      #1;
      if (rsp_valid) break;
    end
    chk("stall_latency", n, L + 3);
    drain();

    // Divide-by-zero followed by a normal divide.
    post(1, 50, 0);
    drain();
    post(1, 50, 5);
    drain();

    // Flush with three operations in flight.
    post(0, 11, 3);  cycle(1'b1, 1'b0);
    post(1, 22, 4);  cycle(1'b1, 1'b0);
    post(0, 33, -5); cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    post(1, -77, 5);
    drain();

    // Asynchronous reset mid-flight.
    post(0, 900, 9); cycle(1'b1, 1'b0);
    post(1, 800, 8); cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    req_valid = '1;
    clk_en    = 1'b1;
    #1;
    check_all_zero("midreset");
    sb.delete();
    ptr  = N - 1;
    pend = '0;
    @(negedge clk);
    req_valid = '0;
    reset     = 1'b0;
    post(0, 45, 4);
    post(1, 46, 4);
    drain();

    // Randomized traffic with stalls, drops and occasional flushes.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0)
          post(i, $urandom_range(0, 2000000) - 1000000, $urandom_range(0, 40) - 20);
        else if (pend[i] && $urandom_range(0, 19) == 0)
          pend[i] = 1'b0;
      end
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0);
    end
    pend = '0;
    drain();
    @(negedge clk);
    chk("final_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
